// File: rtl/audio_bar_meter.sv
// -----------------------------------------------------------------------------
// audio_bar_meter
//   Multi-channel audio level meter sitting between the CODEC sample path and
//   the VGA bar renderer. Each accepted sample vector is processed one channel
//   at a time (ABS -> SCALE -> UPDATE), so a single multiplier serves every
//   channel. Bar heights jump up immediately on louder input and fall by
//   DECAY_STEP pixels on every decay tick, which is only applied while IDLE.
//
//   Optional build macro: AUDIO_BAR_PEAK_HOLD_EN
//     defined   : per-channel peak marker with hold counter, decremented on
//                 frame_start once the hold expires, never below the level.
//     undefined : peak mirrors level, no peak/hold registers are built.
//
// Ports
//   CLOCK_50     in   system clock
//   reset        in   synchronous, active-high reset
//   s_valid      in   sample vector valid
//   s_ready      out  meter can accept a vector (high only in IDLE)
//   s_data       in   CHANNELS*DATA_W, channel c at [c*DATA_W +: DATA_W]
//   frame_start  in   one-cycle pulse per VGA frame
//   level        out  CHANNELS*9, bar height of channel c at [c*9 +: 9]
//   level_valid  out  one-cycle pulse once all channels are updated
//   peak         out  CHANNELS*9, peak marker height per channel
//   clipped      out  CHANNELS, sticky full-scale-negative flags
// -----------------------------------------------------------------------------
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a vector; pending decay applied here
// ABS     | magnitude of current channel, clip detection
// SCALE   | magnitude * BAR_H >> (DATA_W-1) into a 9-bit height
// UPDATE  | raise level of current channel, advance or finish
// DONE    | level_valid pulse, back to IDLE
// -----------------------------------------------------------------------------
module audio_bar_meter #(
  parameter int DATA_W     = 24,
  parameter int CHANNELS   = 2,
  parameter int BAR_H      = 480,
  parameter int DECAY_DIV  = 500000,
  parameter int DECAY_STEP = 1,
  parameter int HOLD_TICKS = 32
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*DATA_W-1:0]   s_data,
  input  logic                         frame_start,
  output logic [CHANNELS*9-1:0]        level,
  output logic                         level_valid,
  output logic [CHANNELS*9-1:0]        peak,
  output logic [CHANNELS-1:0]          clipped
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = MAG_W + 10;
  localparam logic [8:0] STEP9 = 9'(DECAY_STEP);

  generate
    if ((CHANNELS < 1) || (BAR_H < 1) || (BAR_H > 512) || (DECAY_DIV < 1) ||
        (DECAY_STEP < 0) || (HOLD_TICKS < 0)) begin : g_param_check
      $error("audio_bar_meter: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_SCALE,
    ST_UPDATE,
    ST_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [CHANNELS*DATA_W-1:0]    sample_q, sample_d;
  logic [MAG_W-1:0]              mag_q, mag_d;
  logic [8:0]                    h_q, h_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          pend_q, pend_d;
  logic [CHANNELS-1:0]           clip_q, clip_d;
  logic [8:0]                    level_q [CHANNELS];
  logic [8:0]                    level_d [CHANNELS];

  logic [DATA_W-1:0]             cur_s;
  logic                          cur_is_min;
  logic [MAG_W-1:0]              cur_mag;
  logic [PROD_W-1:0]             prod;
  logic                          tick;
  logic                          decay_now;

  // Current channel sample and its magnitude. The most negative code has no
  // positive counterpart, so it saturates to full scale and flags a clip.
  always_comb begin
    cur_s      = sample_q[ch_q*DATA_W +: DATA_W];
    cur_is_min = (cur_s == {1'b1, {MAG_W{1'b0}}});
    if (cur_is_min) begin
      cur_mag = '1;
    end else if (cur_s[DATA_W-1]) begin
      cur_mag = MAG_W'(-cur_s);
    end else begin
      cur_mag = cur_s[MAG_W-1:0];
    end
  end

  // Shared scaling multiplier; mag < 2^(DATA_W-1) keeps the result < BAR_H.
  assign prod = PROD_W'(mag_q) * PROD_W'(BAR_H);

  // Decay timer: free-running, a wrap raises the pending flag. Ticks that
  // land while busy collapse into one pending decay applied back in IDLE.
  assign tick      = (cnt_q == CNT_W'(DECAY_DIV - 1));
  assign decay_now = (state_q == ST_IDLE) && pend_q;

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    pend_d = tick | (pend_q & ~decay_now);
  end

  // Sequencer
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    sample_d = sample_q;
    mag_d    = mag_q;
    h_d      = h_q;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          sample_d = s_data;
          ch_d     = '0;
          state_d  = ST_ABS;
        end
      end
      ST_ABS: begin
        mag_d   = cur_mag;
        state_d = ST_SCALE;
      end
      ST_SCALE: begin
        h_d     = 9'(prod >> MAG_W);
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_ABS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Levels: decay only in IDLE, rise only in UPDATE, so the two never collide.
  always_comb begin
    level_d = level_q;
    if (decay_now) begin
      for (int c = 0; c < CHANNELS; c++) begin
        level_d[c] = (level_q[c] >= STEP9) ? (level_q[c] - STEP9) : 9'd0;
      end
    end
    if ((state_q == ST_UPDATE) && (h_q > level_q[ch_q])) begin
      level_d[ch_q] = h_q;
    end
  end

  // Clip flags: frame_start clears, a coincident set takes priority.
  always_comb begin
    clip_d = frame_start ? '0 : clip_q;
    if ((state_q == ST_ABS) && cur_is_min) begin
      clip_d[ch_q] = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      sample_q <= '0;
      mag_q    <= '0;
      h_q      <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      clip_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        level_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      sample_q <= sample_d;
      mag_q    <= mag_d;
      h_q      <= h_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      clip_q   <= clip_d;
      level_q  <= level_d;
    end
  end

  assign s_ready     = (state_q == ST_IDLE);
  assign level_valid = (state_q == ST_DONE);
  assign clipped     = clip_q;

  always_comb begin
    level = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      level[c*9 +: 9] = level_q[c];
    end
  end

`ifdef AUDIO_BAR_PEAK_HOLD_EN
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic [8:0]        peak_q [CHANNELS];
  logic [8:0]        peak_d [CHANNELS];
  logic [HOLD_W-1:0] hold_q [CHANNELS];
  logic [HOLD_W-1:0] hold_d [CHANNELS];

  // A new maximum in UPDATE re-arms the hold and beats a coincident
  // frame_start. Otherwise frame_start first drains the hold, then walks the
  // marker down one pixel per frame until it meets the level.
  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((state_q == ST_UPDATE) && (ch_q == CH_W'(c)) &&
          (level_d[c] > peak_q[c])) begin
        peak_d[c] = level_d[c];
        hold_d[c] = HOLD_W'(HOLD_TICKS);
      end else if (frame_start) begin
        if (hold_q[c] != '0) begin
          hold_d[c] = hold_q[c] - HOLD_W'(1);
        end else if (peak_q[c] > level_q[c]) begin
          peak_d[c] = peak_q[c] - 9'd1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        peak_q[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    peak = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      peak[c*9 +: 9] = peak_q[c];
    end
  end
`else
  assign peak = level;
`endif

endmodule

// File: doc/audio_bar_meter.md
Name: audio_bar_meter

Overview:
- Multi-channel audio level meter between the audio CODEC sample path and the VGA bar renderer in the DE1_SoC visualizer.
- Accepts one signed sample per channel per handshake and converts each magnitude to a bar height in pixels.
- Bar heights rise instantly on louder input and fall at a programmable decay rate.
- Processes channels sequentially, one pipeline step per cycle, to share a single multiplier.

Parameters:
- DATA_W, 24: signed sample width per channel.
- CHANNELS, 2: number of channels; must be ≥1.
- BAR_H, 480: full-scale bar height in pixels; must be ≤512 (heights are 9 bits).
- DECAY_DIV, 500000: CLOCK_50 cycles between decay ticks; must be ≥1.
- DECAY_STEP, 1: pixels subtracted from every level per decay tick.
- HOLD_TICKS, 32: frame_start pulses for which a peak is held (used only with the optional feature).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  sample vector valid.
- s_ready  out  1  meter can accept a sample vector.
- s_data  in  CHANNELS*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W], two's complement.
- frame_start  in  1  one-cycle pulse per VGA frame.
- level  out  CHANNELS*9  bar height for channel c at [c*9 +: 9].
- level_valid  out  1  one-cycle pulse when all levels have been updated from a new vector.
- peak  out  CHANNELS*9  peak marker height per channel.
- clipped  out  CHANNELS  sticky per-channel full-scale-negative flag.

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is CLOCK_50 and the reset port is reset.
- Reset values:
  - all level, peak and clipped bits 0;
  - level_valid 0;
  - FSM in IDLE, so s_ready = 1;
  - decay counter 0, decay pending flag 0.
- FSM states: IDLE, ABS, SCALE, UPDATE, DONE. s_ready = (state==IDLE).
- IDLE:
  - On s_valid && s_ready: latch s_data, set ch=0, go to ABS.
  - Otherwise, if decay pending: every level = max(level - DECAY_STEP, 0), clear pending.
  - If a handshake and pending decay occur in the same cycle: apply the decay in that cycle, then process the sample.
- ABS:
  - mag = |sample[ch]|, DATA_W-1 bits.
  - sample == -2^(DATA_W-1): mag = 2^(DATA_W-1)-1 (saturated), and set clipped[ch]. Go to SCALE.
- SCALE:
  - h = (mag * BAR_H) >> (DATA_W-1), truncating. Result is 0..BAR_H-1, 9 bits.
  - Go to UPDATE.
- UPDATE:
  - If h > level[ch], level[ch] = h; otherwise level[ch] is unchanged.
  - If ch == CHANNELS-1, go to DONE; else ch++ and go to ABS.
- DONE: level_valid = 1 for this cycle only; go to IDLE.
- Latency: level_valid is asserted exactly 3*CHANNELS+1 cycles after the handshake cycle. Throughput is one vector per 3*CHANNELS+2 cycles.
- Decay timer:
  - Free-running counter 0..DECAY_DIV-1; wraps to 0 and generates a tick.
  - A tick sets the pending flag. Multiple ticks while busy coalesce into one pending decay.
  - Decay is never applied outside IDLE, so the UPDATE compare sees a stable level.
- clipped[c]:
  - Sticky; cleared on frame_start.
  - If a set and a frame_start clear coincide, the set wins.
- Reset mid-operation: the in-flight vector is discarded with no level_valid; all state returns to reset values on the next edge.
- s_data is sampled only on handshake; changes while busy are ignored.

Optional Feature:
- Macro: AUDIO_BAR_PEAK_HOLD_EN.
- Defined:
  - Per-channel peak register plus hold counter (width clog2(HOLD_TICKS+1)).
  - In UPDATE, if the new level > peak[c]: peak[c] = new level and hold[c] = HOLD_TICKS.
  - On frame_start: if hold[c] > 0, hold[c]--; else if peak[c] > level[c], peak[c]--.
  - peak[c] never drops below level[c].
  - A peak update in UPDATE takes priority over a coincident frame_start decrement.
- Not defined: peak = level combinationally, and no hold registers are built.

Test Plan (DATA_W=24, CHANNELS=2, BAR_H=480, DECAY_DIV=8, DECAY_STEP=1, HOLD_TICKS=2):
- Reset for 2 cycles → level=0, peak=0, clipped=0, level_valid=0, s_ready=1.
- Accept ch0=0x7FFFFF, ch1=0x000000 → level_valid on cycle handshake+7; level0=479, level1=0; s_ready=0 for cycles +1..+7.
- Accept ch0=0x800000 → level0=479, clipped[0]=1. frame_start → clipped[0]=0. frame_start coincident with another 0x800000 → clipped[0] stays 1.
- Accept ch0=0x400000 then idle for 80 cycles → level0=240 immediately, then 230 after 10 ticks. Repeat to saturate at 0, never wrapping to 511.
- Hold s_valid high with continuous vectors → only one handshake per 8 cycles. A tick during busy cycles yields exactly one decrement on return to IDLE. Assert reset at ABS of ch1 → no level_valid, all levels 0.
- With AUDIO_BAR_PEAK_HOLD_EN: ch0=0x400000 (peak0=240), then decay to 235 → peak0 stays 240 for 2 frame_starts, then 239, 238 … 235, and stops at level0.
